// File: rtl/spi_tx_queue_pkg.sv
// Shared definitions for the SPI transmit queue: controller state encoding,
// the WAIT_BUSY timeout length and the default queue depth.
package spi_tx_queue_pkg;

  localparam int DEPTH_DEFAULT = 16;

  // Cycles the controller waits in WAIT_BUSY for the master to raise busy.
  localparam int BUSY_TIMEOUT = 8;
  localparam int TMO_W        = $clog2(BUSY_TIMEOUT);

  // The down-counter runs from BUSY_TIMEOUT-1 to 0, one WAIT_BUSY cycle per value.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_tx_queue_sync_fifo8.sv
// sync_fifo8: byte-wide circular FIFO with a sticky overflow flag.
//   i_clk        system clock, rising edge
//   i_reset_n    synchronous active-low reset
//   i_wr_en      push i_wr_data (dropped and flagged when full with no pop)
//   i_wr_data    byte to push
//   i_rd_en      pop the head (ignored when empty)
//   i_flush      empty the FIFO and clear overflow; wins over push and pop
//   o_rd_data    current head byte (valid when o_count != 0)
//   o_full       o_count == DEPTH
//   o_count      number of stored bytes
//   o_overflow   sticky, set when a push is dropped
module sync_fifo8
  import spi_tx_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic          i_flush,
  output logic [7:0]    o_rd_data,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = i_rd_en && (r_count != '0) && !i_flush;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_push = i_wr_en && !i_flush && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_wr_en && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/spi_tx_queue.sv
// spi_tx_queue: queues bytes for an SPI master, launches one transfer at a
// time and returns the byte received for each completed transfer.
//   clk, reset          system clock; synchronous active-low reset
//   wr_en, wr_data      push a byte to transmit
//   flush               drop all queued bytes and clear overflow
//   full, count         queue status (count excludes the byte in flight)
//   overflow            sticky, set when a push is dropped
//   spi_start           one-cycle start strobe to the master
//   spi_data_in         byte presented to the master, held until next launch
//   spi_busy            master busy flag
//   spi_avail           master received-byte-available flag
//   spi_data_out        byte received by the master
//   rx_data, rx_valid   captured received byte and its one-cycle qualifier
//   done                one-cycle pulse when the last queued transfer completes
//
// state        | meaning
// IDLE         | nothing in flight, waiting for a queued byte
// LAUNCH       | head byte on spi_data_in, spi_start high for this cycle
// WAIT_BUSY    | waiting up to BUSY_TIMEOUT cycles for the master to go busy
// WAIT_DONE    | transfer running, waiting for busy low with avail high
module spi_tx_queue
  import spi_tx_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          spi_start,
  output logic [7:0]    spi_data_in,
  input  logic          spi_busy,
  input  logic          spi_avail,
  input  logic [7:0]    spi_data_out,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          done
);

  state_t           r_state;
  logic [TMO_W-1:0] r_tmo;
  logic             r_spi_start;
  logic [7:0]       r_spi_data_in;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_done;

  logic [7:0] w_head;
  logic [AW:0] w_count;
  logic       w_complete;
  logic       w_launch;
  logic       w_pop;

  assign w_complete = (r_state == ST_WAIT_DONE) && !spi_busy && spi_avail;
  // A flush in the same cycle empties the queue, so nothing is launched.
  assign w_launch   = (w_count != '0) && !flush;
  // The head is popped on the edge that enters LAUNCH, so spi_start and the
  // popped byte are both registered and visible for the whole LAUNCH cycle.
  assign w_pop      = w_launch && ((r_state == ST_IDLE) || w_complete);

  sync_fifo8 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .i_clk      (clk),
    .i_reset_n  (reset),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_rd_en    (w_pop),
    .i_flush    (flush),
    .o_rd_data  (w_head),
    .o_full     (full),
    .o_count    (w_count),
    .o_overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_tmo         <= '0;
      r_spi_start   <= 1'b0;
      r_spi_data_in <= 8'h00;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_spi_start <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state       <= ST_LAUNCH;
            r_spi_start   <= 1'b1;
            r_spi_data_in <= w_head;
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT_BUSY;
          r_tmo   <= TMO_LOAD;
        end
        ST_WAIT_BUSY: begin
          if (spi_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_tmo == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (w_complete) begin
            r_rx_data  <= spi_data_out;
            r_rx_valid <= 1'b1;
            if (w_launch) begin
              r_state       <= ST_LAUNCH;
              r_spi_start   <= 1'b1;
              r_spi_data_in <= w_head;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign count       = w_count;
  assign spi_start   = r_spi_start;
  assign spi_data_in = r_spi_data_in;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign done        = r_done;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Bench for spi_tx_queue: directed phases plus random data and slave latency,
// checked against a queue-level model of accepted bytes, queue occupancy and
// the bytes the slave model returns (received byte = sent byte + 0x97).
module tb_spi_tx_queue;
  import spi_tx_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          spi_start;
  logic [7:0]    spi_data_in;
  logic          spi_busy;
  logic          spi_avail;
  logic [7:0]    spi_data_out;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          done;

  spi_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_avail    (spi_avail),
    .spi_data_out (spi_data_out),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_tx [$];
  logic [7:0] exp_rx [$];
  int  m_count = 0;
  bit  m_ovf   = 1'b0;
  bit  last_pop, last_acc;

  int  n_start = 0, n_rxv = 0, n_done = 0;
  int  slave_mode = 0;   // 0 normal, 1 hold busy, 2 never answer
  bit  slave_kill = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive at a falling edge, advance to the next falling edge and
  // update the model; a pop happened on that rising edge iff spi_start is high.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic fl);
    bit pop, acc;
    wr_en = wr; wr_data = d; flush = fl;
    @(negedge clk);
    wr_en = 1'b0; flush = 1'b0;
    pop = (spi_start === 1'b1);
    acc = wr && !fl && ((m_count < DEPTH) || pop);
    if (fl) begin
      exp_tx.delete();
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      if (acc) exp_tx.push_back(d);
      m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (wr && !acc) m_ovf = 1'b1;
    end
    last_pop = pop;
    last_acc = acc;
    chk("count", 32'(count), 32'(m_count));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("full", 32'(full), 32'(m_count == DEPTH));
  endtask

  task automatic run_until_rx(input string tag, input int limit);
    int k = 0;
    do begin cyc(1'b0, 8'h00, 1'b0); k++; end
    while (rx_valid !== 1'b1 && k < limit);
    chk(tag, 32'(rx_valid), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    bit idle_now;
    do begin
      cyc(1'b0, 8'h00, 1'b0); k++;
      idle_now = (exp_tx.size() == 0) && (exp_rx.size() == 0) &&
                 (dut.r_state == ST_IDLE) && (spi_busy == 1'b0) && (m_count == 0);
    end while (!idle_now && k < 500);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    chk(tag, 32'(idle_now), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"},    32'(count),       32'd0);
    chk({tag, "_full"},     32'(full),        32'd0);
    chk({tag, "_overflow"}, 32'(overflow),    32'd0);
    chk({tag, "_start"},    32'(spi_start),   32'd0);
    chk({tag, "_data_in"},  32'(spi_data_in), 32'd0);
    chk({tag, "_rx_data"},  32'(rx_data),     32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid),    32'd0);
    chk({tag, "_done"},     32'(done),        32'd0);
  endtask

  // SPI slave model: busy after 1..4 cycles, busy for 1..4 cycles (or until
  // released), then one cycle of avail with the reply byte.
  initial begin
    logic [7:0] s_tx;
    spi_busy = 1'b0; spi_avail = 1'b0; spi_data_out = 8'h00;
    forever begin
      @(negedge clk);
      spi_avail = 1'b0;
      if (spi_start === 1'b1 && reset === 1'b1 && slave_mode != 2) begin
        s_tx = spi_data_in;
        repeat ($urandom_range(4, 1)) @(negedge clk);
        spi_busy = 1'b1;
        repeat ($urandom_range(4, 1)) @(negedge clk);
        while (slave_mode == 1 && !slave_kill) @(negedge clk);
        spi_busy = 1'b0;
        if (!slave_kill) begin
          spi_avail    = 1'b1;
          spi_data_out = s_tx + 8'h97;
          exp_rx.push_back(s_tx + 8'h97);
        end
      end
    end
  end

  // Output monitor: launch order, one-cycle start, received bytes, done.
  initial begin
    logic prev_start = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (spi_start === 1'b1) begin
          n_start++;
          chk("start_one_cycle", 32'(prev_start), 32'd0);
          chk("tx_pending", 32'(exp_tx.size() != 0), 32'd1);
          if (exp_tx.size() != 0) begin
            e = exp_tx.pop_front();
            chk("spi_data_in", 32'(spi_data_in), 32'(e));
          end
        end
        if (rx_valid === 1'b1) begin
          n_rxv++;
          chk("rx_pending", 32'(exp_rx.size() != 0), 32'd1);
          if (exp_rx.size() != 0) begin
            e = exp_rx.pop_front();
            chk("rx_data", 32'(rx_data), 32'(e));
          end
        end
        if (done === 1'b1) begin
          n_done++;
          chk("done_with_rx_valid", 32'(rx_valid), 32'd1);
        end
      end
      prev_start = spi_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, st0, dn0, acc_n, k, pre;
    bit saw_full_pushpop;
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;

    // Single byte: start two edges after the write, reply 0x3C with done.
    cyc(1'b1, 8'hA5, 1'b0);
    chk("single_start_early", 32'(spi_start), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("single_start", 32'(spi_start), 32'd1);
    chk("single_data_in", 32'(spi_data_in), 32'hA5);
    run_until_rx("single_rx_valid", 40);
    chk("single_rx_data", 32'(rx_data), 32'h3C);
    chk("single_done", 32'(done), 32'd1);
    drain("single_drain");

    // Burst of four back-to-back writes.
    st0 = n_start; rx0 = n_rxv; dn0 = n_done;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0);
    drain("burst_drain");
    chk("burst_starts", 32'(n_start - st0), 32'd4);
    chk("burst_rx", 32'(n_rxv - rx0), 32'd4);
    chk("burst_done", 32'(n_done - dn0), 32'd1);

    // Overflow with the slave stalled busy, then flush with a write.
    slave_mode = 1;
    cyc(1'b1, 8'h10, 1'b0);
    repeat (10) cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0);
    chk("ovf_full16", 32'(full), 32'd1);
    chk("ovf_count16", 32'(count), 32'd16);
    chk("ovf_not_yet", 32'(overflow), 32'd0);
    cyc(1'b1, 8'hEE, 1'b0);
    chk("ovf_count17", 32'(count), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc(1'b1, 8'hDD, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 8'hCC, 1'b1);
    chk("flush_wr_dropped", 32'(count), 32'd0);
    chk("flush_wr_no_ovf", 32'(overflow), 32'd0);
    rx0 = n_rxv;
    slave_mode = 0;
    run_until_rx("flush_inflight_rx", 40);
    chk("flush_inflight_done", 32'(done), 32'd1);
    drain("flush_drain");

    // Wrap-around: fill, then keep pushing while the slave drains.
    slave_mode = 1;
    cyc(1'b1, 8'($urandom), 1'b0);
    acc_n = 1;
    repeat (10) cyc(1'b0, 8'h00, 1'b0);
    while (m_count < DEPTH) begin
      cyc(1'b1, 8'($urandom), 1'b0);
      if (last_acc) acc_n++;
    end
    cyc(1'b1, 8'($urandom), 1'b0);
    slave_mode = 0;
    saw_full_pushpop = 1'b0;
    k = 0;
    while (acc_n < 40 && k < 3000) begin
      pre = m_count;
      cyc((m_count == DEPTH) ? 1'b1 : 1'($urandom_range(3, 0) != 0), 8'($urandom), 1'b0);
      if (last_acc) acc_n++;
      if (pre == DEPTH && last_pop && last_acc) begin
        saw_full_pushpop = 1'b1;
        chk("wrap_full_pushpop_count", 32'(count), 32'd16);
      end
      k++;
    end
    chk("wrap_accepted", 32'(acc_n >= 40), 32'd1);
    chk("wrap_saw_full_pushpop", 32'(saw_full_pushpop), 32'd1);
    drain("wrap_drain");

    // Timeout: the slave never goes busy.
    slave_mode = 2;
    rx0 = n_rxv; dn0 = n_done;
    cyc(1'b1, 8'h77, 1'b0);
    k = 0;
    do begin cyc(1'b0, 8'h00, 1'b0); k++; end while (!last_pop && k < 10);
    chk("tmo_launch", 32'(last_pop), 32'd1);
    repeat (8) cyc(1'b0, 8'h00, 1'b0);
    chk("tmo_still_waiting", 32'(dut.r_state), 32'(ST_WAIT_BUSY));
    cyc(1'b0, 8'h00, 1'b0);
    chk("tmo_idle", 32'(dut.r_state), 32'(ST_IDLE));
    repeat (5) cyc(1'b0, 8'h00, 1'b0);
    chk("tmo_no_rx", 32'(n_rxv), 32'(rx0));
    chk("tmo_no_done", 32'(n_done), 32'(dn0));
    slave_mode = 0;

    // Reset while a transfer is in WAIT_DONE with bytes still queued.
    slave_mode = 1;
    cyc(1'b1, 8'h5E, 1'b0);
    repeat (8) cyc(1'b0, 8'h00, 1'b0);
    chk("rst_wait_done", 32'(dut.r_state), 32'(ST_WAIT_DONE));
    cyc(1'b1, 8'h61, 1'b0);
    cyc(1'b1, 8'h62, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    reset = 1'b1;
    m_count = 0; m_ovf = 1'b0; exp_tx.delete();
    slave_kill = 1'b1; slave_mode = 0;
    rx0 = n_rxv; dn0 = n_done; st0 = n_start;
    repeat (20) cyc(1'b0, 8'h00, 1'b0);
    slave_kill = 1'b0;
    chk("rst_no_rx", 32'(n_rxv), 32'(rx0));
    chk("rst_no_done", 32'(n_done), 32'(dn0));
    chk("rst_no_start", 32'(n_start), 32'(st0));

    // Queue still usable after the reset.
    cyc(1'b1, 8'h3B, 1'b0);
    run_until_rx("post_rst_rx", 40);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_queue.md
SPI_TX_QUEUE -- requirements
Module: spi_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of TX FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter AW, default 4, meaning the FIFO address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1 bit: pushes wr_data into the FIFO.
REQ-006 SHALL have port wr_data, input, 8 bits: byte to transmit.
REQ-007 SHALL have port flush, input, 1 bit: discards all queued bytes and clears overflow.
REQ-008 SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-009 SHALL have port count, output, AW+1 bits: number of queued bytes, excluding the in-flight byte.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-011 SHALL have port spi_start, output, 1 bit: start strobe to the SPI master.
REQ-012 SHALL have port spi_data_in, output, 8 bits: byte presented to the SPI master.
REQ-013 SHALL have port spi_busy, input, 1 bit: busy flag from the SPI master.
REQ-014 SHALL have port spi_avail, input, 1 bit: received-byte-available flag from the SPI master.
REQ-015 SHALL have port spi_data_out, input, 8 bits: byte received by the SPI master.
REQ-016 SHALL have port rx_data, output, 8 bits: captured received byte.
REQ-017 SHALL have port rx_valid, output, 1 bit: one-cycle pulse qualifying rx_data.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when the queue drains and the last transfer completes.

Function
REQ-019 SHALL implement a DEPTH-entry circular FIFO with AW-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-020 SHALL accept wr_en when not full; wr_en while full SHALL drop the byte, leave count unchanged and set overflow.
REQ-021 SHALL keep count unchanged when a push and a pop occur in the same cycle, including at full.
REQ-022 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-023 SHALL transition IDLE->LAUNCH when count>0; in LAUNCH it SHALL pop the head into spi_data_in and drive spi_start=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-024 SHALL, with the FIFO empty and the FSM in IDLE, assert spi_start on the second rising edge after the wr_en cycle.
REQ-025 SHALL hold spi_data_in stable from LAUNCH until the next LAUNCH.
REQ-026 SHALL move from WAIT_BUSY to WAIT_DONE on spi_busy=1.
REQ-027 SHALL return from WAIT_BUSY to IDLE if spi_busy has not risen within 8 cycles, dropping the byte, with no rx_valid and no done.
REQ-028 SHALL, in WAIT_DONE on spi_busy=0 and spi_avail=1, register spi_data_out into rx_data and pulse rx_valid the next cycle.
REQ-029 SHALL, on that completion, go to LAUNCH if count>0, otherwise go to IDLE and pulse done together with rx_valid.
REQ-030 SHALL, on flush, empty the FIFO (count=0, pointers equal) and clear overflow; an in-flight transfer completes and its rx_valid is still produced.
REQ-031 SHALL give flush priority over a simultaneous wr_en, dropping the write without setting overflow.
REQ-032 SHALL never assert spi_start while in WAIT_BUSY or WAIT_DONE.

Reset
REQ-033 SHALL, when reset=0 at a rising edge, force state=IDLE, pointers=0, count=0, full=0, overflow=0, spi_start=0, spi_data_in=0, rx_data=0, rx_valid=0, done=0, and clear the timeout counter.
REQ-034 SHALL abandon any in-flight transfer on reset mid-operation and produce no rx_valid or done for it.

Structure
REQ-035 SHALL place the FSM state encoding, the WAIT_BUSY timeout constant (8) and the default DEPTH in the shared SPI package.
REQ-036 SHALL implement the FIFO storage and pointers as one sub-module, sync_fifo8; the FSM lives in spi_tx_queue.

Verification
REQ-037 Single byte: write 0xA5 into an empty, idle queue; slave model returns 0x3C -> spi_start two edges later with spi_data_in=0xA5, then rx_data=0x3C with rx_valid and done pulsing together.
REQ-038 Burst: write 0x01..0x04 back-to-back -> four spi_start pulses in order 0x01..0x04, four rx_valid pulses, one done after the fourth.
REQ-039 Overflow: write 17 bytes while the slave is stalled busy -> full=1 at 16, 17th byte dropped, overflow=1; flush -> count=0, overflow=0.
REQ-040 Wrap-around: push and pop 40 bytes in total, with a simultaneous push and pop at count=16 -> count stays 16 and byte order is preserved across pointer wrap.
REQ-041 Timeout: spi_busy held at 0 after spi_start -> FSM in IDLE after 8 cycles, no rx_valid.
REQ-042 Reset mid-transfer: reset=0 during WAIT_DONE -> all outputs at reset values next edge; no rx_valid or done afterwards.
